// File: rtl/wb_regfile.sv
// Write-back select and 32x32 register file with two combinational read ports
// and a retired-write counter. Optional write-through bypass: WB_BYPASS_EN.
module wb_regfile (
    input  logic        clk,
    input  logic        clrn,
    input  logic        wwreg,
    input  logic        wm2reg,
    input  logic [4:0]  wrd,
    input  logic [31:0] wresult,
    input  logic [31:0] wdataout,
    input  logic [4:0]  rna,
    input  logic [4:0]  rnb,
    output logic [31:0] qa,
    output logic [31:0] qb,
    output logic [31:0] wdi,
    output logic [31:0] wcnt
);

    logic [31:0] regs_q [32];
    logic [31:0] wcnt_q, wcnt_d;
    logic        commit;

    assign wdi    = wm2reg ? wdataout : wresult;
    assign commit = wwreg && (wrd != 5'd0);
    assign wcnt_d = wcnt_q + 32'd1;
    assign wcnt   = wcnt_q;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            wcnt_q <= '0;
        end else if (commit) begin
            regs_q[wrd] <= wdi;
            wcnt_q      <= wcnt_d;
        end
    end

    always_comb begin
        qa = (rna == 5'd0) ? 32'd0 : regs_q[rna];
        qb = (rnb == 5'd0) ? 32'd0 : regs_q[rnb];
`ifdef WB_BYPASS_EN
        // Bypass is held off during reset so the ports read zero throughout.
        if (commit && !clrn && (rna == wrd)) qa = wdi;
        if (commit && !clrn && (rnb == wrd)) qb = wdi;
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes expectations from an
// array-based model, a monitor pops and compares them against the ports.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        clrn;
    logic        wwreg, wm2reg;
    logic [4:0]  wrd, rna, rnb;
    logic [31:0] wresult, wdataout;
    logic [31:0] qa, qb, wdi, wcnt;

    wb_regfile dut (
        .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wrd(wrd),
        .wresult(wresult), .wdataout(wdataout), .rna(rna), .rnb(rnb),
        .qa(qa), .qb(qb), .wdi(wdi), .wcnt(wcnt)
    );

    always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] wdi;
        logic [31:0] wcnt;
    } exp_t;

    exp_t        sb[$];
    event        sample_ev;
    int          errors = 0;
    int          checks = 0;

    // Reference model: plain array of register contents and a commit count.
    logic [31:0] mdl_reg [32];
    logic [31:0] mdl_cnt;

    function automatic logic [31:0] mdl_wdi();
        return wm2reg ? wdataout : wresult;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [4:0] r);
        if (clrn || r == 0) return 32'd0;
        if (BYPASS && wwreg && wrd == r) return mdl_wdi();
        return mdl_reg[r];
    endfunction

    task automatic expect_now(input string name);
        exp_t e;
        e.name = name;
        e.qa   = mdl_read(rna);
        e.qb   = mdl_read(rnb);
        e.wdi  = mdl_wdi();
        e.wcnt = clrn ? 32'd0 : mdl_cnt;
        sb.push_back(e);
        ->sample_ev;
        #2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl_reg[i] = 32'd0;
        mdl_cnt = 32'd0;
    endtask

    task automatic model_edge();
        if (clrn) model_reset();
        else if (wwreg && wrd != 0) begin
            mdl_reg[wrd] = mdl_wdi();
            mdl_cnt      = mdl_cnt + 32'd1;
        end
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] dout,
                         input logic [4:0] ra, input logic [4:0] rb);
        wwreg = we; wm2reg = m2r; wrd = rd; wresult = res; wdataout = dout;
        rna = ra; rnb = rb;
    endtask

    // One cycle: check before the edge, clock it, check after with inputs held.
    task automatic step(input string name);
        expect_now({name, "_pre"});
        @(posedge clk);
        model_edge();
        #1;
        expect_now({name, "_post"});
    endtask

    task automatic cmp(input string name, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%08h required=%08h", name, fld, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.name, "qa", qa, e.qa);
                cmp(e.name, "qb", qb, e.qb);
                cmp(e.name, "wdi", wdi, e.wdi);
                cmp(e.name, "wcnt", wcnt, e.wcnt);
            end
        end
    end

    initial begin : stim
        logic [4:0] rd;
        model_reset();
        clrn = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        #3;
        expect_now("reset");
        @(posedge clk); model_edge(); #1;
        clrn = 1'b0;
        #1;

        // Source select
        drive(1'b1, 1'b0, 5'd3, 32'hAAAA_0001, 32'h5555_0002, 5'd3, 5'd0);
        step("sel_alu");
        drive(1'b1, 1'b1, 5'd3, 32'hAAAA_0001, 32'h5555_0002, 5'd3, 5'd3);
        step("sel_mem");

        // r0 protection
        drive(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd3);
        step("r0_wr");

        // wwreg = 0 hold
        drive(1'b1, 1'b0, 5'd9, 32'h0000_0042, 32'h0, 5'd9, 5'd9);
        step("r9_init");
        drive(1'b0, 1'b0, 5'd9, 32'h0000_0077, 32'h0, 5'd9, 5'd9);
        step("r9_hold");

        // Same-cycle read/write of r7
        drive(1'b1, 1'b0, 5'd7, 32'h0000_0001, 32'h0, 5'd0, 5'd0);
        step("r7_init");
        drive(1'b1, 1'b1, 5'd7, 32'h0, 32'hDEAD_BEEF, 5'd7, 5'd7);
        step("r7_rw");

        // Randomized traffic, read ports often aimed at the write target
        for (int n = 0; n < 200; n++) begin
            rd = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), rd, $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom),
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom));
            step("rand");
        end

        // Reset mid-run after r5 write, observed before any edge
        drive(1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'h0, 5'd5, 5'd5);
        step("r5_wr");
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);
        #1;
        clrn = 1'b1;
        model_reset();
        #1;
        expect_now("rst_async");
        // Write at an edge while reset is still high is dropped
        drive(1'b1, 1'b0, 5'd5, 32'h0BAD_0BAD, 32'h0, 5'd5, 5'd5);
        step("rst_wr");
        clrn = 1'b0;
        #1;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);
        step("post_rst");

        // Counter wrap from a forced preload
        force dut.wcnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.wcnt_q;
        mdl_cnt = 32'hFFFF_FFFE;
        #1;
        drive(1'b1, 1'b0, 5'd1, 32'h11, 32'h0, 5'd1, 5'd2);
        step("wrap1");
        drive(1'b1, 1'b0, 5'd2, 32'h22, 32'h0, 5'd1, 5'd2);
        step("wrap2");
        cmp("wrap_zero", "wcnt", wcnt, 32'd0);

        #5;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
